// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ADD/SUB/AND/OR/XOR/SLT/SLTU ALU, LSB first, WIDTH cycles per op.
// Optional zero flag output rsp_zero is enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             rsp_zero
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res;
  logic [2:0] op;
  logic [CW-1:0] cnt;
  logic carry, sub, cmp, bb, sum, cout, rb, flag, last;
  assign sub = op == 3'd1 || op == 3'd5 || op == 3'd6;
  assign cmp = op == 3'd5 || op == 3'd6;
  assign bb = b_sh[0] ^ sub;
  assign sum = a_sh[0] ^ bb ^ carry;
  assign cout = (a_sh[0] & bb) | (carry & (a_sh[0] ^ bb));
  assign rb = op == 3'd0 || op == 3'd1 ? sum :
              op == 3'd2 ? a_sh[0] & b_sh[0] :
              op == 3'd3 ? a_sh[0] | b_sh[0] :
              op == 3'd4 ? a_sh[0] ^ b_sh[0] : 1'b0;
  // Evaluated only in the final RUN cycle, when a_sh[0]/b_sh[0] hold the operand MSBs.
  assign flag = op == 3'd5 ? (a_sh[0] != b_sh[0] ? a_sh[0] : sum) : ~cout;
  assign last = cnt == CW'(WIDTH - 1);
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic nz;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      rsp_result <= '0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      nz <= 1'b0;
      rsp_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= RUN;
          a_sh <= req_a;
          b_sh <= req_b;
          op <= req_op;
          cnt <= '0;
          carry <= req_op == 3'd1 || req_op == 3'd5 || req_op == 3'd6;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          nz <= 1'b0;
`endif
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res <= {rb, res[WIDTH-2:1]};
          carry <= cout;
          cnt <= last ? '0 : cnt + 1'b1;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          nz <= nz | rb;
`endif
          if (last) begin
            state <= DONE;
            rsp_result <= cmp ? {{(WIDTH-1){1'b0}}, flag} : {rb, res};
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            rsp_zero <= cmp ? ~flag : ~(nz | rb);
`endif
          end
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed-vector bench for serial_alu_seq at WIDTH = 32.
module tb_serial_alu_seq;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, busy;
  logic [2:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0, rsp_result;
  int n = 0, fails = 0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic rsp_zero;
`endif
  serial_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    req_valid = 1; req_op = o; req_a = a; req_b = b;
    chk({tag, " ready"}, req_ready, 1);
    tick();
    req_valid = 0; req_op = 3'd2; req_a = $urandom; req_b = $urandom;
    chk({tag, " run0"}, {rsp_valid, busy, req_ready}, 3'b010);
    for (int i = 1; i < 32; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b1) chk({tag, " early"}, {rsp_valid, busy}, 2'b01);
    end
    tick();
    chk({tag, " valid@32"}, {rsp_valid, busy}, 2'b11);
    chk({tag, " result"}, rsp_result, exp);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    chk({tag, " zero"}, rsp_zero, exp == 0);
`endif
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0]; req_op = 3'd3; req_a = $urandom; req_b = $urandom;
      tick();
      chk({tag, " hold"}, {rsp_valid, req_ready, busy, rsp_result}, {3'b101, exp});
    end
    req_valid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, " idle"}, {rsp_valid, req_ready, busy}, 3'b010);
    chk({tag, " retain"}, rsp_result, exp);
  endtask
  initial begin
    tick();
    tick();
    chk("reset outs", {req_ready, rsp_valid, busy, rsp_result}, 35'h0);
    rst = 0;
    #1;
    chk("ready after rst", req_ready, 1);
    run_op("add wrap", 3'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 0);
    run_op("sub", 3'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 0);
    run_op("xor", 3'd4, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 0);
    run_op("and", 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0);
    run_op("or", 3'd3, 32'h12340000, 32'h00005678, 32'h12345678, 0);
    run_op("slt neg", 3'd5, 32'h80000000, 32'h1, 32'h1, 0);
    run_op("sltu big", 3'd6, 32'h80000000, 32'h1, 32'h0, 0);
    run_op("slt pos", 3'd5, 32'h7FFFFFFF, 32'h80000000, 32'h0, 0);
    run_op("sltu small", 3'd6, 32'h1, 32'h80000000, 32'h1, 0);
    run_op("slt eq", 3'd5, 32'h55, 32'h55, 32'h0, 0);
    run_op("rsvd", 3'd7, 32'h12345678, 32'h12345678, 32'h0, 0);
    run_op("add 1+1", 3'd0, 32'h1, 32'h1, 32'h2, 0);
    run_op("backpressure", 3'd0, 32'd10, 32'd20, 32'd30, 10);
    req_valid = 1; req_op = 3'd0; req_a = 32'hFFFF; req_b = 32'h1;
    tick();
    req_valid = 0;
    for (int i = 0; i < 16; i++) tick();
    rst = 1;
    #1;
    chk("ready in rst", req_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("abort idle", {rsp_valid, busy, req_ready, rsp_result}, {3'b001, 32'h0});
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) chk("abort no rsp", {rsp_valid, busy}, 2'b00);
    end
    run_op("add after rst", 3'd0, 32'd3, 32'd4, 32'd7, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
